// File: rtl/seg7_scan_mux_if.sv
// Display-side bundle for the seven-segment scan driver.
// Host side drives digit data and refresh; driver side drives the pins.
interface seg7_scan_mux_if;
    logic        refresh_in;
    logic [15:0] digits_bcd;
    logic [3:0]  dp_en;
    logic        blank_lead_zero;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output refresh_in,
        output digits_bcd,
        output dp_en,
        output blank_lead_zero,
        input  an,
        input  seg,
        input  dp
    );

    modport slave (
        input  refresh_in,
        input  digits_bcd,
        input  dp_en,
        input  blank_lead_zero,
        output an,
        output seg,
        output dp
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed seven-segment driver with anti-ghost blanking.
// Steps on both refresh edges, decodes BCD, suppresses leading zeros.
module seg7_scan_mux #(
    parameter int BLANK_CYCLES = 1000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input logic            clk,
    input logic            rst,
    seg7_scan_mux_if.slave io_disp
);

    localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST =
        (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
    localparam logic POL = ACTIVE_LOW;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    logic          r_s1;
    logic          r_s2;
    logic          r_prev;
    logic [1:0]    r_arm_cnt;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    state_t        w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic [1:0]    w_idx_next;
    logic          w_step;
    logic [3:0]    w_digit;
    logic          w_dp_sel;
    logic [6:0]    w_pat;
    logic          w_z3;
    logic          w_z2;
    logic          w_z1;
    logic          w_blank;
    logic [3:0]    w_onehot;

    // Synchronise refresh and hold off stepping until the pipe is primed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_prev    <= 1'b0;
            r_arm_cnt <= 2'd0;
        end else begin
            r_s1   <= io_disp.refresh_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            if (r_arm_cnt != 2'd3) begin
                r_arm_cnt <= r_arm_cnt + 2'd1;
            end
        end
    end

    assign w_step = (r_arm_cnt == 2'd3) && (r_s2 != r_prev);

    // Scan state, blank counter and digit index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next-state: a step always restarts the blank gap on the new digit
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        unique case (r_state)
            ST_BLANK: begin
                if (w_step) begin
                    w_idx_next = r_idx + 2'd1;
                    w_cnt_next = '0;
                end else if (BLANK_CYCLES == 0 || r_cnt == LAST) begin
                    w_state_next = ST_SHOW;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_SHOW: begin
                if (w_step) begin
                    w_idx_next   = r_idx + 2'd1;
                    w_cnt_next   = '0;
                    w_state_next = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                end
            end
        endcase
    end

    assign w_digit  = io_disp.digits_bcd[{r_idx, 2'b00} +: 4];
    assign w_dp_sel = io_disp.dp_en[r_idx];
    assign w_onehot = 4'b0001 << r_idx;
    assign w_z3 = (io_disp.digits_bcd[15:12] == 4'd0);
    assign w_z2 = w_z3 && (io_disp.digits_bcd[11:8] == 4'd0);
    assign w_z1 = w_z2 && (io_disp.digits_bcd[7:4] == 4'd0);

    // Leading-zero decision for the selected digit; digit 0 always shows
    always_comb begin
        w_blank = 1'b0;
        unique case (r_idx)
            2'd3: w_blank = w_z3;
            2'd2: w_blank = w_z2;
            2'd1: w_blank = w_z1;
            2'd0: w_blank = 1'b0;
        endcase
        w_blank = w_blank && io_disp.blank_lead_zero;
    end

    // BCD to {g,f,e,d,c,b,a}, active-high; non-decimal codes show a dash
    always_comb begin
        w_pat = 7'h40;
        case (w_digit)
            4'd0: w_pat = 7'h3F;
            4'd1: w_pat = 7'h06;
            4'd2: w_pat = 7'h5B;
            4'd3: w_pat = 7'h4F;
            4'd4: w_pat = 7'h66;
            4'd5: w_pat = 7'h6D;
            4'd6: w_pat = 7'h7D;
            4'd7: w_pat = 7'h07;
            4'd8: w_pat = 7'h7F;
            4'd9: w_pat = 7'h6F;
            default: w_pat = 7'h40;
        endcase
    end

    // Registered pins: lit digit only in SHOW, polarity applied here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= {4{POL}};
            r_seg <= {7{POL}};
            r_dp  <= POL;
        end else if (r_state == ST_SHOW) begin
            r_an  <= w_onehot ^ {4{POL}};
            r_seg <= (w_blank ? 7'h00 : w_pat) ^ {7{POL}};
            r_dp  <= w_dp_sel ^ POL;
        end else begin
            r_an  <= {4{POL}};
            r_seg <= {7{POL}};
            r_dp  <= POL;
        end
    end

    assign io_disp.an  = r_an;
    assign io_disp.seg = r_seg;
    assign io_disp.dp  = r_dp;

endmodule
